// File: rtl/fifo_byte_reader_pkg.sv
// Shared definitions for the FIFO byte reader: FSM state encodings and lane sizing helper.
package fifo_byte_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SEND  = 2'd2
   } state_t;

   // A single-lane word still needs a 1-bit lane register to stay legal.
   function automatic int lane_bits(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

endpackage

// File: rtl/fifo_byte_reader.sv
// Splits first-word-fall-through FIFO words into OUT_WIDTH beats with valid/ready handshake.
// Lane order is LSB first by default; define FIFO_READER_MSB_FIRST_EN for MSB-first lanes.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no transfer; waits for i_start
// ST_FETCH | transfer active, waiting for a FIFO word (o_valid low)
// ST_SEND  | presenting lane beats of the word register (o_valid high)
module fifo_byte_reader
   import fifo_byte_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int OUT_WIDTH  = 8,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_flush,
   input  logic                  i_start,
   input  logic [LEN_WIDTH-1:0]  i_length,
   input  logic [DATA_WIDTH-1:0] i_fifo_data,
   input  logic                  i_fifo_empty,
   output logic                  o_fifo_read_enable,
   output logic [OUT_WIDTH-1:0]  o_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int                   LANES     = DATA_WIDTH / OUT_WIDTH;
   localparam int                   LANE_W    = lane_bits(LANES);
   localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(LANES - 1);
   localparam logic [LEN_WIDTH-1:0] ONE       = LEN_WIDTH'(1);

   state_t                  state;
   logic [LEN_WIDTH-1:0]    remaining;
   logic [LANE_W-1:0]       lane;
   logic [DATA_WIDTH-1:0]   word;
   logic                    last_beat;
   logic                    wrap_lane;
   logic                    fetch_now;

   // Terminal count of the beat down-counter.
   assign last_beat = (remaining == ONE);
   assign wrap_lane = (lane == LAST_LANE);

   always_comb begin
      fetch_now = 1'b0;
      if (!i_flush && !i_fifo_empty) begin
         case (state)
            ST_FETCH: fetch_now = 1'b1;
            ST_SEND:  fetch_now = i_ready && wrap_lane && !last_beat;
            default:  fetch_now = 1'b0;
         endcase
      end
   end

   assign o_fifo_read_enable = fetch_now;

   always_comb begin
`ifdef FIFO_READER_MSB_FIRST_EN
      o_data = OUT_WIDTH'(word >> ((LANES - 1 - int'(lane)) * OUT_WIDTH));
`else
      o_data = OUT_WIDTH'(word >> (int'(lane) * OUT_WIDTH));
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         remaining <= '0;
         lane      <= '0;
         word      <= '0;
         o_valid   <= 1'b0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (i_flush) begin
            state     <= ST_IDLE;
            remaining <= '0;
            lane      <= '0;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (i_start) begin
                     if (i_length != '0) begin
                        remaining <= i_length;
                        state     <= ST_FETCH;
                        o_busy    <= 1'b1;
                     end else begin
                        o_done <= 1'b1;
                     end
                  end
               end
               ST_FETCH: begin
                  if (!i_fifo_empty) begin
                     word    <= i_fifo_data;
                     lane    <= '0;
                     state   <= ST_SEND;
                     o_valid <= 1'b1;
                  end
               end
               ST_SEND: begin
                  if (i_ready) begin
                     remaining <= remaining - ONE;
                     if (last_beat) begin
                        // Unsent lanes of the final word are dropped here.
                        state   <= ST_IDLE;
                        lane    <= '0;
                        o_valid <= 1'b0;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                     end else if (wrap_lane) begin
                        lane <= '0;
                        if (!i_fifo_empty) begin
                           word <= i_fifo_data;
                        end else begin
                           state   <= ST_FETCH;
                           o_valid <= 1'b0;
                        end
                     end else begin
                        lane <= lane + 1'b1;
                     end
                  end
               end
               default: begin
                  state   <= ST_IDLE;
                  o_valid <= 1'b0;
                  o_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fifo_byte_reader.sv
// Bench for fifo_byte_reader: directed scenarios plus randomized transfers against a beat-list model.
// Honours FIFO_READER_MSB_FIRST_EN for the expected lane order.
module tb_fifo_byte_reader;

   localparam int DW    = 32;
   localparam int OW    = 8;
   localparam int LW    = 16;
   localparam int LANES = DW / OW;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          i_flush = 1'b0;
   logic          i_start = 1'b0;
   logic [LW-1:0] i_length = '0;
   logic [DW-1:0] i_fifo_data = '0;
   logic          i_fifo_empty = 1'b1;
   logic          i_ready = 1'b0;
   logic          o_fifo_read_enable;
   logic [OW-1:0] o_data;
   logic          o_valid;
   logic          o_busy;
   logic          o_done;

   fifo_byte_reader #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .LEN_WIDTH(LW)) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .i_flush            (i_flush),
      .i_start            (i_start),
      .i_length           (i_length),
      .i_fifo_data        (i_fifo_data),
      .i_fifo_empty       (i_fifo_empty),
      .o_fifo_read_enable (o_fifo_read_enable),
      .o_data             (o_data),
      .o_valid            (o_valid),
      .i_ready            (i_ready),
      .o_busy             (o_busy),
      .o_done             (o_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_tick   = 0;
   int n_reads  = 0;
   int beats    = 0;
   int first_tick = -1;
   int last_tick  = -1;

   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] pend_q[$];
   logic [DW-1:0] xfer_words[$];
   logic [OW-1:0] exp_q[$];

   logic          m_busy = 1'b0;
   logic          m_done = 1'b0;
   logic          feed_fast = 1'b1;
   logic          flushed = 1'b0;
   logic          prev_valid = 1'b0;
   logic          prev_hs = 1'b0;
   logic [OW-1:0] prev_data = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected beat list: lanes of the transfer's words in order, cut at len.
   task automatic load_expected(input int len);
      exp_q.delete();
      for (int k = 0; k < len; k++) begin
         logic [DW-1:0] w;
         int            ln;
         w  = xfer_words[k / LANES];
         ln = k % LANES;
`ifdef FIFO_READER_MSB_FIRST_EN
         ln = LANES - 1 - ln;
`endif
         exp_q.push_back(OW'(w >> (OW * ln)));
      end
   endtask

   // One clock: inputs already driven; sample at negedge, update model, advance past posedge.
   task automatic tick();
      logic          hs;
      logic          rd;
      logic          fl;
      logic          done_n;
      logic [OW-1:0] e;
      i_fifo_empty = (fifo_q.size() == 0);
      i_fifo_data  = i_fifo_empty ? '0 : fifo_q[0];
      @(negedge clk);
      n_tick++;
      check_eq("busy", o_busy, m_busy);
      check_eq("done", o_done, m_done);
      if (!m_busy) check_eq("idle_valid", o_valid, 1'b0);
      if (o_fifo_read_enable) check_eq("rd_nonempty", i_fifo_empty, 1'b0);
      if (i_flush) check_eq("flush_rd", o_fifo_read_enable, 1'b0);
      if (o_valid && prev_valid && !prev_hs) check_eq("stall_stable", o_data, prev_data);
      hs = o_valid && i_ready && !i_flush;
      if (hs) begin
         check_eq("beat_expected", (exp_q.size() == 0), 1'b0);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("beat", o_data, e);
            beats++;
            if (first_tick < 0) first_tick = n_tick;
            last_tick = n_tick;
         end
      end
      rd     = o_fifo_read_enable;
      fl     = i_flush;
      done_n = 1'b0;
      if (i_flush) begin
         m_busy  = 1'b0;
         flushed = 1'b1;
         exp_q.delete();
      end else if (!m_busy) begin
         if (i_start) begin
            if (i_length == '0) begin
               done_n = 1'b1;
            end else begin
               m_busy = 1'b1;
               load_expected(int'(i_length));
            end
         end
      end else if (hs && exp_q.size() == 0) begin
         m_busy = 1'b0;
         done_n = 1'b1;
      end
      prev_valid = o_valid;
      prev_hs    = hs;
      prev_data  = o_data;
      @(posedge clk);
      #1;
      m_done = done_n;
      if (rd && fifo_q.size() != 0) begin
         void'(fifo_q.pop_front());
         n_reads++;
      end
      if (fl) begin
         fifo_q.delete();
         pend_q.delete();
      end else if (pend_q.size() != 0 && (feed_fast || $urandom_range(0, 3) != 0)) begin
         fifo_q.push_back(pend_q.pop_front());
      end
   endtask

   task automatic start_xfer(input int len);
      beats      = 0;
      first_tick = -1;
      last_tick  = -1;
      flushed    = 1'b0;
      i_start    = 1'b1;
      i_length   = LW'(len);
      tick();
      i_start    = 1'b0;
   endtask

   // mode 0: ready held high, 1: ready toggles, 2: random ready/start/flush
   task automatic run_until_idle(input int mode, input bit allow_flush);
      int budget;
      budget = 3000;
      while (m_busy && budget > 0) begin
         case (mode)
            0:       i_ready = 1'b1;
            1:       i_ready = ~i_ready;
            default: i_ready = 1'($urandom_range(0, 1));
         endcase
         if (mode == 2) begin
            i_start  = ($urandom_range(0, 7) == 0);
            i_length = LW'($urandom_range(0, 20));
            i_flush  = allow_flush && ($urandom_range(0, 39) == 0);
         end
         tick();
         budget--;
      end
      i_start = 1'b0;
      i_flush = 1'b0;
      check_eq("xfer_timeout", (budget == 0), 1'b0);
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      int nw;
      int len;

      // reset state
      @(negedge clk);
      check_eq("rst_valid", o_valid, 1'b0);
      check_eq("rst_data", o_data, 8'h00);
      check_eq("rst_busy", o_busy, 1'b0);
      check_eq("rst_done", o_done, 1'b0);
      check_eq("rst_rd", o_fifo_read_enable, 1'b0);
      #2 reset_n = 1'b1;
      @(posedge clk);
      #1;
      tick();

      // two full words, ready held high
      xfer_words = '{32'h44332211, 32'h88776655};
      fifo_q     = xfer_words;
      r0         = n_reads;
      i_ready    = 1'b1;
      start_xfer(8);
      run_until_idle(0, 1'b0);
      check_eq("d1_reads", n_reads - r0, 2);
      check_eq("d1_beats", beats, 8);
      check_eq("d1_consecutive", last_tick - first_tick, 7);

      // partial last word, ready toggling
      xfer_words = '{32'hDDCCBBAA, 32'h000000EE};
      fifo_q     = xfer_words;
      r0         = n_reads;
      i_ready    = 1'b0;
      start_xfer(5);
      run_until_idle(1, 1'b0);
      check_eq("d2_reads", n_reads - r0, 2);
      check_eq("d2_beats", beats, 5);
      check_eq("d2_fifo_left", fifo_q.size(), 0);

      // FIFO runs dry after the first word
      xfer_words = '{32'h04030201, 32'h0A0B0C0D};
      fifo_q.delete();
      fifo_q.push_back(32'h04030201);
      r0      = n_reads;
      i_ready = 1'b1;
      start_xfer(8);
      repeat (8) tick();
      check_eq("d3_gap_valid", o_valid, 1'b0);
      check_eq("d3_gap_beats", beats, 4);
      check_eq("d3_gap_busy", o_busy, 1'b1);
      fifo_q.push_back(32'h0A0B0C0D);
      tick();
      check_eq("d3_resume_valid", o_valid, 1'b1);
`ifdef FIFO_READER_MSB_FIRST_EN
      check_eq("d3_resume_data", o_data, 8'h0A);
`else
      check_eq("d3_resume_data", o_data, 8'h0D);
`endif
      run_until_idle(0, 1'b0);
      check_eq("d3_reads", n_reads - r0, 2);
      check_eq("d3_beats", beats, 8);

      // flush after two beats, then clean restart
      xfer_words = '{32'h44332211, 32'h88776655};
      fifo_q     = xfer_words;
      i_ready    = 1'b1;
      start_xfer(8);
      for (int k = 0; k < 20 && beats < 2; k++) tick();
      check_eq("d4_beats_before_flush", beats, 2);
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      check_eq("d4_flush_valid", o_valid, 1'b0);
      check_eq("d4_flush_busy", o_busy, 1'b0);
      i_ready = 1'b0;
      tick();
      xfer_words = '{32'h0D0C0B0A};
      fifo_q     = xfer_words;
      r0         = n_reads;
      start_xfer(4);
      run_until_idle(0, 1'b0);
      check_eq("d4_restart_beats", beats, 4);
      check_eq("d4_restart_reads", n_reads - r0, 1);

      // zero-length start
      r0 = n_reads;
      i_start  = 1'b1;
      i_length = '0;
      tick();
      i_start = 1'b0;
      check_eq("d5_done", o_done, 1'b1);
      check_eq("d5_valid", o_valid, 1'b0);
      tick();
      check_eq("d5_reads", n_reads - r0, 0);

      // reset mid-transfer
      xfer_words = '{32'h55AA55AA, 32'h12345678};
      fifo_q     = xfer_words;
      i_ready    = 1'b1;
      start_xfer(8);
      repeat (3) tick();
      reset_n = 1'b0;
      #1;
      check_eq("d6_rst_valid", o_valid, 1'b0);
      check_eq("d6_rst_busy", o_busy, 1'b0);
      check_eq("d6_rst_data", o_data, 8'h00);
      check_eq("d6_rst_rd", o_fifo_read_enable, 1'b0);
      m_busy     = 1'b0;
      m_done     = 1'b0;
      prev_valid = 1'b0;
      exp_q.delete();
      fifo_q.delete();
      pend_q.delete();
      #2 reset_n = 1'b1;
      tick();
      tick();

      // randomized transfers with lazy FIFO fill, random ready, spurious starts and flushes
      feed_fast = 1'b0;
      for (int t = 0; t < 30; t++) begin
         len = $urandom_range(1, 20);
         nw  = (len + LANES - 1) / LANES;
         xfer_words.delete();
         for (int k = 0; k < nw; k++) xfer_words.push_back($urandom());
         fifo_q.delete();
         pend_q = xfer_words;
         r0     = n_reads;
         start_xfer(len);
         run_until_idle(2, 1'b1);
         if (!flushed) begin
            check_eq("rnd_reads", n_reads - r0, nw);
            check_eq("rnd_beats", beats, len);
         end
         fifo_q.delete();
         pend_q.delete();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
